// File: rtl/fabric_cfg_loader.sv
// fabric_cfg_loader: assembles a WORD_W-bit stream in a shadow, checks padding (plus an XOR checksum word when FABRIC_CFG_CHECKSUM_EN is defined), then commits it to config_bits and holds fabric_rst_n low for HOLD_CYCLES
module fabric_cfg_loader #(
  parameter int CFG_W = 52,
  parameter int WORD_W = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_valid,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic [CFG_W-1:0]  config_bits,
  output logic              fabric_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int NWORDS = (CFG_W + WORD_W - 1) / WORD_W;
  localparam int SH_W = NWORDS * WORD_W;
  localparam int CNT_W = $clog2(NWORDS + 1);
  localparam int HC_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);
  localparam logic [HC_W-1:0] HLAST = HC_W'(HOLD_CYCLES - 1);
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef FABRIC_CFG_CHECKSUM_EN
    S_CSUM,
`endif
    S_CHECK,
    S_APPLY,
    S_HOLD,
    S_ERR
  } state_t;
`ifdef FABRIC_CFG_CHECKSUM_EN
  localparam state_t S_AFTER = S_CSUM;
`else
  localparam state_t S_AFTER = S_CHECK;
`endif
  state_t r_state, w_next;
  logic [SH_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_cnt;
  logic [HC_W-1:0] r_hcnt;
  logic [CFG_W-1:0] r_cfg;
  logic r_ready, r_rstn, r_busy, r_done, r_err;
  logic w_xfer, w_pad_bad;
`ifdef FABRIC_CFG_CHECKSUM_EN
  logic [WORD_W-1:0] r_xor;
`endif
  assign w_xfer = cfg_valid && r_ready && !abort;
  assign w_pad_bad = (r_shadow >> CFG_W) != '0;
  assign cfg_ready = r_ready;
  assign config_bits = r_cfg;
  assign fabric_rst_n = r_rstn;
  assign busy = r_busy;
  assign done = r_done;
  assign err = r_err;
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = abort ? S_ERR : (w_xfer && r_cnt == LAST) ? S_AFTER : S_LOAD;
`ifdef FABRIC_CFG_CHECKSUM_EN
      S_CSUM:  w_next = abort ? S_ERR : !w_xfer ? S_CSUM : (cfg_data == r_xor) ? S_CHECK : S_ERR;
`endif
      S_CHECK: w_next = w_pad_bad ? S_ERR : S_APPLY;
      S_APPLY: w_next = S_HOLD;
      S_HOLD:  w_next = (r_hcnt == HLAST) ? S_IDLE : S_HOLD;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // Words arrive LSB-first, so shifting each one in from the top leaves word i at [i*WORD_W +: WORD_W] once all are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_cnt <= '0;
      r_hcnt <= '0;
      r_cfg <= '0;
      r_ready <= 1'b0;
      r_rstn <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
`ifdef FABRIC_CFG_CHECKSUM_EN
      r_xor <= '0;
`endif
    end else begin
      r_ready <= (w_next == S_LOAD) || (w_next == S_AFTER && S_AFTER != S_CHECK);
      r_busy <= w_next != S_IDLE;
      r_done <= r_state == S_HOLD && w_next == S_IDLE;
      if (r_state == S_IDLE && start) begin
        r_shadow <= '0;
        r_cnt <= '0;
        r_err <= 1'b0;
`ifdef FABRIC_CFG_CHECKSUM_EN
        r_xor <= '0;
`endif
      end
      if (r_state == S_LOAD && w_xfer) begin
        r_shadow <= {cfg_data, r_shadow[SH_W-1:WORD_W]};
        r_cnt <= r_cnt + 1'b1;
`ifdef FABRIC_CFG_CHECKSUM_EN
        r_xor <= r_xor ^ cfg_data;
`endif
      end
      if (w_next == S_ERR) r_shadow <= '0;
      if (r_state == S_ERR) r_err <= 1'b1;
      if (r_state == S_APPLY) begin
        r_cfg <= r_shadow[CFG_W-1:0];
        r_rstn <= 1'b0;
        r_hcnt <= '0;
      end
      if (r_state == S_HOLD) begin
        r_hcnt <= r_hcnt + 1'b1;
        if (w_next == S_IDLE) r_rstn <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fabric_cfg_loader.sv
// tb_fabric_cfg_loader: randomized and directed loads checked against a word-list reference model
module tb_fabric_cfg_loader;
  localparam int CFG_W = 52;
  localparam int HOLD = 4;
  localparam int NW = 7;
`ifdef FABRIC_CFG_CHECKSUM_EN
  localparam int NS = NW + 1;
`else
  localparam int NS = NW;
`endif
  logic clk = 1'b0;
  logic rst, start, abort, cfg_valid, cfg_ready, fabric_rst_n, busy, done, err;
  logic [7:0] cfg_data;
  logic [CFG_W-1:0] config_bits;
  int n_chk = 0;
  int n_pass = 0;
  logic [CFG_W-1:0] m_cfg;
  logic m_rstn, m_err;
  logic [7:0] w [0:NW];
  fabric_cfg_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .config_bits(config_bits), .fabric_rst_n(fabric_rst_n),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_cfg"}, 64'(config_bits), 64'(m_cfg));
    chk({tag, "_rstn"}, 64'(fabric_rst_n), 64'(m_rstn));
    chk({tag, "_err"}, 64'(err), 64'(m_err));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_ready"}, 64'(cfg_ready), 64'd0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_cfg = '0;
    m_rstn = 1'b0;
    m_err = 1'b0;
    chk_idle("reset");
  endtask
  // gap < 0 means random 0..3 idle cycles before each word; abort_at/rst_at < 0 disable them
  task automatic run_load(input int gap, input int abort_at, input int rst_at);
    logic [63:0] val;
    logic [7:0] x;
    bit ok;
    int g, t;
    val = '0;
    x = '0;
    for (int i = 0; i < NW; i++) begin
      val |= 64'(w[i]) << (8 * i);
      x ^= w[i];
    end
    ok = (val >> CFG_W) == 0 && abort_at < 0;
`ifdef FABRIC_CFG_CHECKSUM_EN
    ok = ok && (w[NW] == x);
`endif
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("busy_load", 64'(busy), 64'd1);
    chk("err_clr", 64'(err), 64'd0);
    for (int i = 0; i < NS; i++) begin
      g = gap < 0 ? $urandom_range(3, 0) : gap;
      for (int c = 0; c < g; c++) begin
        if (i > 0) chk("ready_gap", 64'(cfg_ready), 64'd1);
        cfg_valid = 1'b0;
        start = 1'($urandom_range(1, 0));
        @(negedge clk);
      end
      cfg_valid = 1'b1;
      cfg_data = w[i];
      abort = (i == abort_at);
      start = 1'b0;
      t = 0;
      while (cfg_ready !== 1'b1 && t < 8) begin
        @(negedge clk);
        t++;
      end
      chk("ready_word", 64'(cfg_ready), 64'd1);
      @(negedge clk);
      cfg_valid = 1'b0;
      abort = 1'b0;
      if (i == abort_at) break;
    end
    chk("ready_drop", 64'(cfg_ready), 64'd0);
    if (ok) begin
      for (int j = 1; j <= 4 + HOLD; j++) begin
        chk("cfg", 64'(config_bits), j >= 3 ? 64'(val[CFG_W-1:0]) : 64'(m_cfg));
        chk("rstn", 64'(fabric_rst_n), (j >= 3 && j <= 2 + HOLD) ? 64'd0 : j >= 3 + HOLD ? 64'd1 : 64'(m_rstn));
        chk("done", 64'(done), 64'(j == 3 + HOLD));
        chk("busy", 64'(busy), 64'(j < 3 + HOLD));
        if (j == 3 + HOLD) chk("err_ok", 64'(err), 64'd0);
        start = (j <= 2 + HOLD) ? 1'($urandom_range(1, 0)) : 1'b0;
        if (rst_at >= 0 && j == 3 + rst_at) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          start = 1'b0;
          m_cfg = '0;
          m_rstn = 1'b0;
          m_err = 1'b0;
          chk_idle("hold_rst");
          return;
        end
        @(negedge clk);
      end
      start = 1'b0;
      m_cfg = val[CFG_W-1:0];
      m_rstn = 1'b1;
      m_err = 1'b0;
    end else begin
      for (int j = 1; j <= 4; j++) begin
        chk("e_cfg", 64'(config_bits), 64'(m_cfg));
        chk("e_rstn", 64'(fabric_rst_n), 64'(m_rstn));
        chk("e_done", 64'(done), 64'd0);
        if (j == 4) begin
          chk("e_err", 64'(err), 64'd1);
          chk("e_busy", 64'(busy), 64'd0);
        end
        @(negedge clk);
      end
      m_err = 1'b1;
    end
  endtask
  task automatic set_nominal();
    for (int i = 0; i < NW; i++) w[i] = 8'(i + 1);
    w[NW] = 8'h00;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] x;
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_valid = 1'b0;
    cfg_data = '0;
    do_reset();
    set_nominal();
    run_load(0, -1, -1);
    chk("nominal_cfg", 64'(config_bits), 64'h7_0605_0403_0201);
    run_load(2, -1, -1);
    w[NW-1] = 8'h17;
    run_load(0, -1, -1);
    set_nominal();
    run_load(0, 3, -1);
    run_load(0, -1, -1);
    run_load(0, -1, 2);
    run_load(0, -1, -1);
`ifdef FABRIC_CFG_CHECKSUM_EN
    w[NW] = 8'h01;
    run_load(0, -1, -1);
    set_nominal();
`endif
    for (int n = 0; n < 40; n++) begin
      x = '0;
      for (int i = 0; i < NW; i++) begin
        w[i] = 8'($urandom);
        if (i == NW - 1 && $urandom_range(3, 0) != 0) w[i] &= 8'h0F;
        x ^= w[i];
      end
      w[NW] = ($urandom_range(5, 0) == 0) ? x ^ 8'($urandom_range(255, 1)) : x;
      run_load(-1, $urandom_range(5, 0) == 0 ? int'($urandom_range(NS - 1, 0)) : -1,
               $urandom_range(7, 0) == 0 ? int'($urandom_range(HOLD - 1, 0)) : -1);
      chk_idle("idle");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fabric_cfg_loader.md
Name: fabric_cfg_loader

Overview:
Configuration controller for the 2x2 CLB fabric. It accepts the fabric bitstream as a stream of WORD_W-bit words over a valid/ready handshake and assembles it in a shadow register. It checks the stream, then commits it atomically to the fabric's config_bits bus while holding the fabric in reset for a programmable number of cycles. It sits between the host/wrapper interface and fabric_2x2, and is the only driver of fabric config_bits and fabric reset.

Parameters:
CFG_W, 52, total fabric configuration width (4 CLBs x 13 bits)
WORD_W, 8, width of one stream word
HOLD_CYCLES, 4, cycles fabric_rst_n is held low after commit (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  begin a load; sampled only in IDLE
abort  input  1  cancel an in-progress load
cfg_valid  input  1  stream word valid
cfg_data  input  WORD_W  stream word
cfg_ready  output  1  loader can accept a word
config_bits  output  CFG_W  active fabric configuration (to fabric_2x2)
fabric_rst_n  output  1  active-low reset to fabric_2x2
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on successful commit
err  output  1  sticky error flag, cleared by the next accepted start

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, config_bits=0, fabric_rst_n=0 (fabric stays in reset until the first successful load), cfg_ready=0, busy=0, done=0, err=0, shadow=0, word counter=0.
- NWORDS = ceil(CFG_W/WORD_W), which is 7 at the defaults.
- Word i is written to shadow[i*WORD_W +: WORD_W], LSB-first. Bits of the last word above CFG_W are padding.
- States: IDLE, LOAD, [CSUM], CHECK, APPLY, HOLD, ERR.
- IDLE:
  - cfg_ready=0.
  - start=1 moves to LOAD, clears err, shadow and the counter.
  - start in any other state is ignored.
- LOAD:
  - cfg_ready=1 starting from the first cycle after entry.
  - A transfer happens on cfg_valid & cfg_ready. cfg_valid gaps are allowed; data is captured only on a transfer.
  - After the transfer of word NWORDS-1, go to CHECK (or CSUM when enabled). cfg_ready drops in the next cycle.
  - abort=1 in LOAD: go to ERR and discard the shadow. If abort coincides with a transfer, abort wins and the word is dropped.
- CHECK (1 cycle):
  - Padding bits of the last word nonzero: go to ERR.
  - Otherwise go to APPLY.
- APPLY (1 cycle): config_bits <= shadow, fabric_rst_n <= 0, go to HOLD.
- HOLD:
  - Counts HOLD_CYCLES cycles with fabric_rst_n=0, then returns to IDLE.
  - On return, fabric_rst_n=1 and done=1 for exactly one cycle.
  - abort is ignored in HOLD.
- ERR (1 cycle):
  - err<=1, then go to IDLE.
  - config_bits and fabric_rst_n are left unchanged, so the previous configuration keeps running.
- Latency: last transfer in cycle k; config_bits updates at cycle k+3; fabric_rst_n is low for cycles k+3..k+2+HOLD_CYCLES; done=1 and fabric_rst_n=1 at cycle k+3+HOLD_CYCLES.
- rst asserted in any state, including mid-LOAD or mid-HOLD: all outputs return to their reset values on the next clock.

Optional Feature:
FABRIC_CFG_CHECKSUM_EN:
- Defined:
  - After the NWORDS data words, LOAD goes to CSUM.
  - CSUM accepts one extra word with the same handshake and abort rules as LOAD.
  - The word must equal the XOR of all data words; on mismatch go to ERR, on match go to CHECK.
  - Latency counts from the checksum transfer.
- Undefined: no CSUM state, and the stream is exactly NWORDS words.

Test Plan:
1. Nominal load: after rst, pulse start, send words 0x01..0x07 with no gaps -> config_bits=52'h7_0605_0403_0201; fabric_rst_n low for 4 cycles; then done one-cycle pulse and fabric_rst_n=1; err=0; busy low after done.
2. Backpressure: same words with cfg_valid low for 2 cycles between each word -> identical config_bits; cfg_ready never drops mid-load; exactly 7 words consumed.
3. Padding error: last word 0x17 -> err=1, no done, config_bits unchanged from test 1, fabric_rst_n stays 1.
4. Abort: start, send 3 words, then assert abort together with a valid 4th word -> ERR then IDLE, err=1, config_bits unchanged. A following start clears err and a full load succeeds.
5. Reset mid-HOLD: assert rst two cycles into HOLD -> next cycle config_bits=0, fabric_rst_n=0, busy=0, done=0. start pulsed while busy in any earlier run -> no effect.
6. With FABRIC_CFG_CHECKSUM_EN defined: words 0x01..0x07 plus checksum 0x00 -> commit as in test 1. Checksum 0x01 -> err=1, no commit.
